// File: rtl/alu_op_sequencer.sv
// Multi-cycle front end for the shared LEGv8 ALU: it accepts one instruction, decodes it,
// sequences the ALU through IDLE/DECODE/EXEC/RESP and returns a registered response.
module alu_op_sequencer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              branch_taken,
    output logic              illegal,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StResp} state_e;

    state_e              state_q, state_d;
    logic [31:0]         inst_q, inst_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [3:0]          ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                branch_q, branch_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [10:0]         opcode;
    logic                dec_legal;
    logic                dec_use_imm;
    logic                dec_cbz;
    logic [3:0]          dec_ctrl;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   dec_b;
    logic                unused_inst_low;

    assign opcode          = inst_q[31:21];
    assign imm_ext         = {{(DATA_W-9){inst_q[20]}}, inst_q[20:12]};
    assign dec_b           = dec_use_imm ? imm_ext : b_q;
    // Only the opcode and imm9 fields take part in decode.
    assign unused_inst_low = ^inst_q[11:0];

    always_comb begin
        dec_legal   = 1'b1;
        dec_use_imm = 1'b0;
        dec_cbz     = 1'b0;
        dec_ctrl    = 4'b0000;
        if (inst_q[31:24] == 8'b10110100) begin
            dec_cbz  = 1'b1;
            dec_ctrl = 4'b0111;
        end else begin
            case (opcode)
                11'b10001011000: dec_ctrl = 4'b0010;
                11'b11001011000: dec_ctrl = 4'b0110;
                11'b10001010000: dec_ctrl = 4'b0000;
                11'b10101010000: dec_ctrl = 4'b0001;
                11'b11111000010,
                11'b11111000000: begin
                    dec_ctrl    = 4'b0010;
                    dec_use_imm = 1'b1;
                end
                default:         dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    inst_d  = inst;
                    a_d     = reg_a;
                    b_d     = reg_b;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    ctrl_d  = dec_ctrl;
                    alu_a_d = a_q;
                    alu_b_d = dec_b;
                    state_d = StExec;
                end else begin
                    // ALU drive registers deliberately keep the previous op's values.
                    illegal_d = 1'b1;
                    result_d  = '0;
                    zero_d    = 1'b0;
                    branch_d  = 1'b0;
                    state_d   = StResp;
                end
            end
            StExec: begin
                result_d  = alu_result;
                zero_d    = alu_zero;
                branch_d  = dec_cbz & alu_zero;
                illegal_d = 1'b0;
                state_d   = StResp;
            end
            StResp: begin
                if (out_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q   <= StIdle;
            inst_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= 4'b0000;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StResp);
    assign alu_ctrl     = ctrl_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = branch_q;
    assign illegal      = illegal_q;
    assign op_count     = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a vector table for single ops plus hand-written
// backpressure, mid-op reset and counter-wrap sequences, with a behavioural ALU attached.
module tb_alu_op_sequencer;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   inst = '0;
    logic [DW-1:0] reg_a = '0;
    logic [DW-1:0] reg_b = '0;
    logic [DW-1:0] alu_result;
    logic          alu_zero;

    logic          in_ready, out_valid, zero, branch_taken, illegal;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_a, alu_b, result;
    logic [15:0]   op_count;

    logic          in_ready_w, out_valid_w, zero_w, branch_w, illegal_w;
    logic [3:0]    alu_ctrl_w;
    logic [DW-1:0] alu_a_w, alu_b_w, result_w;
    logic [2:0]    op_count_w;

    int checks = 0;
    int errors = 0;
    int cnt = 0;

    always #5 clk = ~clk;

    // Behavioural model of the external datapath ALU.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    alu_op_sequencer #(.DATA_W(DW), .CNT_W(16)) dut (
        .CLK(clk), .Reset_L(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .reg_a(reg_a), .reg_b(reg_b), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .branch_taken(branch_taken),
        .illegal(illegal), .op_count(op_count)
    );

    // Narrow-counter twin, same stimulus, so counter wrap is reachable in a short run.
    alu_op_sequencer #(.DATA_W(DW), .CNT_W(3)) dut_w (
        .CLK(clk), .Reset_L(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .inst(inst),
        .reg_a(reg_a), .reg_b(reg_b), .alu_ctrl(alu_ctrl_w), .alu_a(alu_a_w), .alu_b(alu_b_w),
        .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid_w),
        .out_ready(out_ready), .result(result_w), .zero(zero_w), .branch_taken(branch_w),
        .illegal(illegal_w), .op_count(op_count_w)
    );

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
        logic [63:0] alu_b;
        logic [63:0] res;
        logic        z;
        logic        br;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        chk("in_ready_idle", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1;
        inst     = i;
        reg_a    = a;
        reg_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reg_a    = ~a;
        reg_b    = ~b;
        inst     = 32'h0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        out_ready = 1'b1;
        start_op(v.inst, v.a, v.b);
        wait_valid(lat);
        chk({v.name, "_latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, "_ctrl"}, {60'b0, alu_ctrl}, {60'b0, v.ctrl});
        chk({v.name, "_alu_b"}, alu_b, v.alu_b);
        chk({v.name, "_result"}, result, v.res);
        chk({v.name, "_zero"}, {63'b0, zero}, {63'b0, v.z});
        chk({v.name, "_branch"}, {63'b0, branch_taken}, {63'b0, v.br});
        chk({v.name, "_illegal"}, {63'b0, illegal}, {63'b0, v.ill});
        chk({v.name, "_result_w"}, result_w, v.res);
        @(posedge clk);
        cnt++;
        @(negedge clk);
        chk({v.name, "_out_valid_drop"}, {63'b0, out_valid}, 64'd0);
        chk({v.name, "_op_count"}, {48'b0, op_count}, 64'(cnt & 16'hFFFF));
        chk({v.name, "_op_count_w"}, {61'b0, op_count_w}, 64'(cnt & 7));
    endtask

    initial begin
        int lat;
        vecs[0] = '{"add",   32'h8B000000, 64'd5,      64'd7,      4'b0010, 64'd7,
                    64'd12, 1'b0, 1'b0, 1'b0, 3};
        vecs[1] = '{"sub",   32'hCB000000, 64'h1234,   64'h1234,   4'b0110, 64'h1234,
                    64'd0, 1'b1, 1'b0, 1'b0, 3};
        vecs[2] = '{"ldur",  32'hF85F8000, 64'd100,    64'hDEAD,   4'b0010,
                    64'hFFFF_FFFF_FFFF_FFF8, 64'd92, 1'b0, 1'b0, 1'b0, 3};
        vecs[3] = '{"cbz0",  32'hB4000040, 64'd9,      64'd0,      4'b0111, 64'd0,
                    64'd0, 1'b1, 1'b1, 1'b0, 3};
        vecs[4] = '{"cbz3",  32'hB4000040, 64'd9,      64'd3,      4'b0111, 64'd3,
                    64'd3, 1'b0, 1'b0, 1'b0, 3};
        vecs[5] = '{"and",   32'h8A000000, 64'hF0F0,   64'h0FF0,   4'b0000, 64'h0FF0,
                    64'h00F0, 1'b0, 1'b0, 1'b0, 3};
        vecs[6] = '{"orr",   32'hAA000000, 64'hF000,   64'h000F,   4'b0001, 64'h000F,
                    64'hF00F, 1'b0, 1'b0, 1'b0, 3};
        vecs[7] = '{"stur",  32'hF8005000, 64'h10,     64'd77,     4'b0010, 64'd5,
                    64'h15, 1'b0, 1'b0, 1'b0, 3};
        vecs[8] = '{"illeg", 32'hFFE00000, 64'd1,      64'd2,      4'b0010, 64'd5,
                    64'd0, 1'b0, 1'b0, 1'b1, 2};
        vecs[9] = '{"addz",  32'h8B000000, {64{1'b1}}, 64'd1,      4'b0010, 64'd1,
                    64'd0, 1'b1, 1'b0, 1'b0, 3};

        // Reset state
        #2;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_alu_ctrl", {60'b0, alu_ctrl}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_op_count", {48'b0, op_count}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven ops; the 8th completion wraps the 3-bit twin counter to zero.
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Illegal op under backpressure, with in_valid pulsed while busy.
        out_ready = 1'b0;
        start_op(32'hFFE00000, 64'd3, 64'd4);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            inst     = 32'h8B000000;
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
            chk("bp_illegal", {63'b0, illegal}, 64'd1);
            chk("bp_result", result, 64'd0);
            chk("bp_alu_ctrl", {60'b0, alu_ctrl}, 64'b0010);
            chk("bp_alu_b", alu_b, 64'd1);
            chk("bp_op_count", {48'b0, op_count}, 64'(cnt));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        cnt++;
        @(negedge clk);
        chk("bp_release_count", {48'b0, op_count}, 64'(cnt));
        chk("bp_release_valid", {63'b0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'b0, in_ready}, 64'd1);

        // Asynchronous reset while in EXEC drops the op and clears everything.
        start_op(32'h8B000000, 64'h55, 64'h66);
        @(negedge clk);
        @(negedge clk);
        chk("exec_in_ready", {63'b0, in_ready}, 64'd0);
        chk("exec_alu_ctrl", {60'b0, alu_ctrl}, 64'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_alu_ctrl", {60'b0, alu_ctrl}, 64'd0);
        chk("mid_rst_alu_a", alu_a, 64'd0);
        chk("mid_rst_alu_b", alu_b, 64'd0);
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_flags", {61'b0, zero, branch_taken, illegal}, 64'd0);
        chk("mid_rst_op_count", {48'b0, op_count}, 64'd0);
        chk("mid_rst_op_count_w", {61'b0, op_count_w}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt   = 0;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
